// File: rtl/scanout_pkg.sv
// Shared types and default sizing for the mem_scanout frame reader.
package scanout_pkg;
  localparam int unsigned A_DEF     = 10;
  localparam int unsigned S_DEF     = 24;
  localparam int unsigned DEPTH_DEF = 512;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;
endpackage

// File: rtl/mem_scanout_if.sv
// Pixel stream bundle carrying mem_scanout's pix_* signals between source and sink.
interface mem_scanout_if
  import scanout_pkg::*;
#(
  parameter int unsigned S = S_DEF
);
  logic [S-1:0] pix_data;
  logic         pix_valid;
  logic         pix_ready;
  logic         pix_last;

  modport master (output pix_data, pix_valid, pix_last, input pix_ready);
  modport slave  (input pix_data, pix_valid, pix_last, output pix_ready);
endinterface

// File: rtl/scanout_fifo.sv
// Two-entry FIFO buffering memory read data ahead of the pixel stream.
module scanout_fifo #(
  parameter int unsigned S = 24
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [S-1:0] wdata_i,
  output logic [S-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);
  logic [S-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/mem_scanout.sv
// Scans DEPTH words out of a 1-cycle-latency memory into a valid/ready pixel stream.
// Define SCANOUT_LOOP_EN to restart each frame automatically after the first start.
module mem_scanout
  import scanout_pkg::*;
#(
  parameter int unsigned A     = A_DEF,
  parameter int unsigned S     = S_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  output logic [A-1:0] mem_address,
  input  logic [S-1:0] mem_data,
  output logic [S-1:0] pix_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         pix_last,
  output logic         busy,
  output logic         frame_done
);
  state_t       state_q;
  logic [A-1:0] addr_q;
  logic         inflight_q, inflight_last_q;
  logic         frame_done_q;

  logic [S:0]   fifo_rdata;
  logic         fifo_full, fifo_empty;
  logic [1:0]   fifo_count;
  logic         pop, issue, addr_last;
  logic [2:0]   occ;

  scanout_fifo #(.S(S + 1)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .wdata_i ({inflight_last_q, mem_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pix_valid   = !fifo_empty;
  assign pix_data    = fifo_rdata[S-1:0];
  assign pix_last    = !fifo_empty && fifo_rdata[S];
  assign pop         = pix_valid && pix_ready;
  assign mem_address = addr_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign addr_last   = (addr_q == A'(DEPTH - 1));

  // Occupancy counts the head leaving this cycle as already gone, so reads keep
  // streaming at one per cycle while the sink accepts every pixel.
  assign occ = 3'(fifo_count) - 3'(pop) + 3'(inflight_q);

  always_comb begin
    issue = 1'b0;
    unique case (state_q)
      IDLE:    issue = start;
      RUN:     issue = (occ < 3'd2);
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      inflight_q   <= issue;
      frame_done_q <= 1'b0;
      if (issue) begin
        inflight_last_q <= addr_last;
        if (addr_last) begin
          addr_q  <= '0;
          state_q <= DRAIN;
        end else begin
          addr_q  <= addr_q + A'(1);
          state_q <= RUN;
        end
      end
      if (state_q == DRAIN && pop && fifo_rdata[S]) begin
        frame_done_q <= 1'b1;
`ifdef SCANOUT_LOOP_EN
        state_q      <= RUN;
`else
        state_q      <= IDLE;
`endif
      end
    end
  end

  assert property (@(posedge clock) disable iff (reset) !(inflight_q && fifo_full && !pop));
endmodule

// File: tb/tb_mem_scanout.sv
// Directed bench for mem_scanout with DEPTH 4, 512 and 1 instances sharing one memory image.
module tb_mem_scanout;
  localparam int unsigned AW = 10;
  localparam int unsigned SW = 24;

  logic clk = 1'b0;
  logic rst;
  logic ready;
  logic start4, start512, start1;
  always #5 clk = ~clk;

  logic [AW-1:0] addr4, addr512, addr1;
  logic [SW-1:0] md4, md512, md1;
  logic          busy4, busy512, busy1;
  logic          fd4, fd512, fd1;

  mem_scanout_if #(.S(SW)) if4 ();
  mem_scanout_if #(.S(SW)) if512 ();
  mem_scanout_if #(.S(SW)) if1 ();
  assign if4.pix_ready   = ready;
  assign if512.pix_ready = ready;
  assign if1.pix_ready   = ready;

  mem_scanout #(.A(AW), .S(SW), .DEPTH(4)) dut4 (
    .clock(clk), .reset(rst), .start(start4), .mem_address(addr4), .mem_data(md4),
    .pix_data(if4.pix_data), .pix_valid(if4.pix_valid), .pix_ready(if4.pix_ready),
    .pix_last(if4.pix_last), .busy(busy4), .frame_done(fd4));
  mem_scanout #(.A(AW), .S(SW), .DEPTH(512)) dut512 (
    .clock(clk), .reset(rst), .start(start512), .mem_address(addr512), .mem_data(md512),
    .pix_data(if512.pix_data), .pix_valid(if512.pix_valid), .pix_ready(if512.pix_ready),
    .pix_last(if512.pix_last), .busy(busy512), .frame_done(fd512));
  mem_scanout #(.A(AW), .S(SW), .DEPTH(1)) dut1 (
    .clock(clk), .reset(rst), .start(start1), .mem_address(addr1), .mem_data(md1),
    .pix_data(if1.pix_data), .pix_valid(if1.pix_valid), .pix_ready(if1.pix_ready),
    .pix_last(if1.pix_last), .busy(busy1), .frame_done(fd1));

  logic [SW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    md4   <= mem[addr4];
    md512 <= mem[addr512];
    md1   <= mem[addr1];
  end

  int            sel;
  logic [AW-1:0] o_addr;
  logic [SW-1:0] o_data;
  logic          o_valid, o_last, o_busy, o_fd;
  always_comb begin
    case (sel)
      0: begin o_addr = addr4; o_data = if4.pix_data; o_valid = if4.pix_valid;
               o_last = if4.pix_last; o_busy = busy4; o_fd = fd4; end
      1: begin o_addr = addr512; o_data = if512.pix_data; o_valid = if512.pix_valid;
               o_last = if512.pix_last; o_busy = busy512; o_fd = fd512; end
      default: begin o_addr = addr1; o_data = if1.pix_data; o_valid = if1.pix_valid;
               o_last = if1.pix_last; o_busy = busy1; o_fd = fd1; end
    endcase
  end

  int unsigned   checks = 0, errors = 0;
  int unsigned   acc, lasts, fd_seen;
  logic          exp_fd, stalled;
  logic [SW-1:0] held;
  logic [SW:0]   sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    acc = 0; lasts = 0; fd_seen = 0;
  endtask

  task automatic push_frame(input int unsigned depth);
    logic [SW:0] e;
    for (int unsigned k = 0; k < depth; k++) begin
      e[SW]      = (k == depth - 1);
      e[SW-1:0]  = SW'(k * 16);
      sb.push_back(e);
    end
  endtask

  // One clock cycle: observe the current cycle, then advance to #1 after the next edge.
  task automatic step();
    logic        fd_next;
    logic [SW:0] e;
    fd_next = 1'b0;
    check("frame_done", 32'(o_fd), 32'(exp_fd));
    if (stalled) begin
      check("stall_valid", 32'(o_valid), 32'd1);
      check("stall_data", 32'(o_data), 32'(held));
    end
    if (o_valid === 1'b1 && ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL extra_pixel observed=%0h expected=none", o_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pix_data", 32'(o_data), 32'(e[SW-1:0]));
        check("pix_last", 32'(o_last), 32'(e[SW]));
        fd_next = e[SW];
      end
      acc++;
      if (o_last) lasts++;
    end
    if (o_fd === 1'b1) fd_seen++;
    stalled = o_valid && !ready;
    held    = o_data;
    @(posedge clk);
    #1;
    exp_fd = fd_next;
  endtask

  task automatic run_frame(input int unsigned budget, input bit rnd, output int unsigned n);
    n = 0;
    while ((sb.size() != 0 || o_busy) && n < budget) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    ready = 1'b1;
    check("frame_timeout", 32'(n < budget), 32'd1);
    step();
    check("frame_done_count", fd_seen, 32'd1);
  endtask

  task automatic reset_checks();
    check("rst_addr", 32'(o_addr), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_fd", 32'(o_fd), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
  endtask

  task automatic start_pulse(input int which);
    case (which)
      0: start4 = 1'b1;
      1: start512 = 1'b1;
      default: start1 = 1'b1;
    endcase
    step();
    start4 = 1'b0; start512 = 1'b0; start1 = 1'b0;
  endtask

  initial begin
    int unsigned n;
    for (int unsigned k = 0; k < (1 << AW); k++) mem[k] = SW'(k * 16);
    rst = 1'b1; ready = 1'b1; start4 = 1'b0; start512 = 1'b0; start1 = 1'b0;
    sel = 0; exp_fd = 1'b0; stalled = 1'b0; held = '0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      reset_checks();
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef SCANOUT_LOOP_EN
    // One start, two back-to-back frames, busy never drops.
    sel = 0; clear_counts();
    push_frame(4); push_frame(4);
    start_pulse(0);
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      check("loop_busy", 32'(o_busy), 32'd1);
      step();
      n++;
    end
    check("loop_timeout", 32'(n < 60), 32'd1);
    step();
    check("loop_fd_count", fd_seen, 32'd2);
    check("loop_busy_after", 32'(o_busy), 32'd1);
    check("loop_lasts", lasts, 32'd2);
    rst = 1'b1;
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst = 1'b0;
`else
    // DEPTH=4, ready high: 0x00..0x30, first pixel two cycles after start.
    sel = 0; clear_counts();
    push_frame(4);
    start_pulse(0);
    check("lat_c1_valid", 32'(o_valid), 32'd0);
    step();
    check("lat_c2_valid", 32'(o_valid), 32'd1);
    check("first_pixel", 32'(o_data), 32'h00);
    run_frame(50, 1'b0, n);
    check("throughput4", n, 32'd4);
    check("count4", acc, 32'd4);
    check("lasts4", lasts, 32'd1);
    check("idle4", 32'(o_busy), 32'd0);

    // start while RUN is ignored.
    clear_counts();
    push_frame(4);
    start_pulse(0);
    step();
    start_pulse(0);
    run_frame(50, 1'b0, n);
    repeat (6) step();
    check("restart_ignored_count", acc, 32'd4);
    check("restart_ignored_idle", 32'(o_busy), 32'd0);

    // DEPTH=1: a single pixel carrying pix_last.
    sel = 2; clear_counts();
    push_frame(1);
    start_pulse(2);
    run_frame(20, 1'b0, n);
    check("count1", acc, 32'd1);
    check("lasts1", lasts, 32'd1);

    // Three-cycle stall mid-frame with read-ahead bounded to two.
    sel = 1; clear_counts();
    push_frame(512);
    start_pulse(1);
    n = 0;
    while (acc < 10 && n < 100) begin step(); n++; end
    ready = 1'b0;
    repeat (3) begin
      check("outstanding_le2", 32'((int'(o_addr) - int'(acc)) <= 2), 32'd1);
      step();
    end
    ready = 1'b1;
    run_frame(2000, 1'b0, n);
    check("count_stall", acc, 32'd512);
    check("lasts_stall", lasts, 32'd1);

    // Random backpressure over a full frame.
    clear_counts();
    push_frame(512);
    start_pulse(1);
    run_frame(5000, 1'b1, n);
    check("count_rand", acc, 32'd512);
    check("lasts_rand", lasts, 32'd1);

    // Reset at pixel 100 aborts the frame; restart begins at address 0.
    clear_counts();
    push_frame(512);
    start_pulse(1);
    n = 0;
    while (acc < 100 && n < 300) begin step(); n++; end
    rst = 1'b1;
    #1;
    reset_checks();
    sb.delete();
    stalled = 1'b0;
    exp_fd  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    check("abort_no_fd", fd_seen, 32'd0);
    clear_counts();
    push_frame(512);
    start_pulse(1);
    run_frame(2000, 1'b0, n);
    check("count_restart", acc, 32'd512);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
